// File: rtl/prod_accumulator.sv
// Accumulates a run of unsigned 16-bit product beats into an ACC_W-bit sum with a valid/ready
// result handshake. Define PROD_ACC_SAT_EN for saturating overflow; otherwise the sum wraps.
module prod_accumulator #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      prod,
  input  logic [CNT_W-1:0] len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf
);

  if (ACC_W < 17) begin : gen_acc_w_check
    $error("prod_accumulator: ACC_W must be at least 17");
  end

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W:0]     sum;
  logic               carry;

  // One extra bit captures the carry-out of every addition.
  assign sum   = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, prod};
  assign carry = sum[ACC_W];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          acc_d = {{(ACC_W - 16){1'b0}}, prod};
          ovf_d = 1'b0;
          // len of 0 or 1 both mean a single-beat accumulation.
          if (len <= CntOne) begin
            rem_d   = '0;
            state_d = StDone;
          end else begin
            rem_d   = len - CntOne;
            state_d = StAcc;
          end
        end
      end
      StAcc: begin
        if (in_valid) begin
          rem_d = rem_q - CntOne;
`ifdef PROD_ACC_SAT_EN
          if (carry || ovf_q) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
`else
          acc_d = sum[ACC_W-1:0];
          ovf_d = ovf_q | carry;
`endif
          if (rem_q == CntOne) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs are forced low combinationally while reset is held.
  always_comb begin
    in_ready  = !rst && (state_q != StDone);
    out_valid = !rst && (state_q == StDone);
    acc_out   = acc_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_prod_accumulator.sv
// Self-checking bench for prod_accumulator: a 24-bit and a 17-bit instance share stimulus and
// are compared every cycle against an unbounded-sum transaction model.
module tb_prod_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] prod;
  logic [7:0]  len;
  logic        out_ready;

  logic        in_ready24, out_valid24, ovf24;
  logic [23:0] acc24;
  logic        in_ready17, out_valid17, ovf17;
  logic [16:0] acc17;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  bit          started = 1'b0;

  always #5 clk = ~clk;

  prod_accumulator #(.ACC_W(24), .CNT_W(8)) u_dut24 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready24), .prod(prod), .len(len),
    .out_valid(out_valid24), .out_ready(out_ready), .acc_out(acc24), .ovf(ovf24)
  );

  prod_accumulator #(.ACC_W(17), .CNT_W(8)) u_dut17 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready17), .prod(prod), .len(len),
    .out_valid(out_valid17), .out_ready(out_ready), .acc_out(acc17), .ovf(ovf17)
  );

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction model: true (unbounded) running sum, beat count and target length.
  longint unsigned m_sum = 0;
  int              m_cnt = 0;
  int              m_target = 0;
  bit              m_active = 1'b0;
  bit              m_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sum = 0; m_cnt = 0; m_target = 0; m_active = 1'b0; m_done = 1'b0;
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (in_valid) begin
      if (!m_active) begin
        m_sum    = longint'(prod);
        m_target = (len == 0) ? 1 : int'(len);
        m_cnt    = 1;
      end else begin
        m_sum += longint'(prod);
        m_cnt++;
      end
      m_active = (m_cnt != m_target);
      m_done   = (m_cnt == m_target);
    end
  end

  function automatic longint unsigned exp_acc(input longint unsigned s, input int w);
    longint unsigned lim = longint'(1) << w;
`ifdef PROD_ACC_SAT_EN
    return (s >= lim) ? lim - 1 : s;
`else
    return s % lim;
`endif
  endfunction

  always @(negedge clk) begin
    if (started) begin
      check("in_ready24", in_ready24, !rst && !m_done);
      check("out_valid24", out_valid24, !rst && m_done);
      check("in_ready17", in_ready17, !rst && !m_done);
      check("out_valid17", out_valid17, !rst && m_done);
      if (!rst && m_done) begin
        check("acc24", acc24, exp_acc(m_sum, 24));
        check("ovf24", ovf24, m_sum >= (longint'(1) << 24));
        check("acc17", acc17, exp_acc(m_sum, 17));
        check("ovf17", ovf17, m_sum >= (longint'(1) << 17));
      end
    end
  end

  task automatic beat(input logic [15:0] p, input logic [7:0] l);
    in_valid = 1'b1; prod = p; len = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_out_valid", out_valid24, 1'b0);
    check("drain_in_ready", in_ready24, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; prod = '0; len = '0; out_ready = 1'b0;
    started = 1'b1;
    #2;
    check("rst_in_ready", in_ready24, 1'b0);
    check("rst_out_valid", out_valid24, 1'b0);
    check("rst_acc", acc24, 24'd0);
    check("rst_ovf", ovf24, 1'b0);
    idle(2);
    rst = 1'b0;
    idle(1);

    // Four back-to-back beats; result visible right after the 4th accepting edge.
    beat(16'd10, 8'd4); beat(16'd20, 8'd0); beat(16'd30, 8'd0); beat(16'd40, 8'd0);
    check("b2b_out_valid", out_valid24, 1'b1);
    check("b2b_acc", acc24, 24'd100);
    check("b2b_ovf", ovf24, 1'b0);
    drain();

    // len=0 behaves as a single beat.
    beat(16'h1234, 8'd0);
    check("len0_out_valid", out_valid24, 1'b1);
    check("len0_acc", acc24, 24'h001234);
    drain();

    // Overflow in the 17-bit instance.
    beat(16'hFFFF, 8'd3); beat(16'hFFFF, 8'd0); beat(16'hFFFF, 8'd0);
`ifdef PROD_ACC_SAT_EN
    check("ovf17_acc", acc17, 17'h1FFFF);
`else
    check("ovf17_acc", acc17, 17'd65533);
`endif
    check("ovf17_flag", ovf17, 1'b1);
    check("ovf24_acc", acc24, 24'h02FFFD);
    drain();

    // Gapped beats, then backpressure with ignored beats, release with in_valid still high.
    beat(16'd100, 8'd3); idle(2); beat(16'd200, 8'd9); idle(1); beat(16'd300, 8'd9);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; prod = 16'(i * 7 + 1); len = 8'd2;
      @(posedge clk); #1;
      check("hold_acc", acc24, 24'd600);
      check("hold_in_ready", in_ready24, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("release_out_valid", out_valid24, 1'b0);
    check("release_in_ready", in_ready24, 1'b1);
    check("release_acc_kept", acc24, 24'd600);

    // Reset mid-accumulation discards the partial sum.
    beat(16'd5, 8'd4); beat(16'd6, 8'd0);
    rst = 1'b1; #1;
    check("midrst_acc", acc24, 24'd0);
    check("midrst_in_ready", in_ready24, 1'b0);
    idle(1);
    rst = 1'b0;
    beat(16'd7, 8'd1);
    check("after_rst_valid", out_valid24, 1'b1);
    check("after_rst_acc", acc24, 24'd7);
    drain();

    // Longest run at full-scale products.
    for (int i = 0; i < 255; i++) beat(16'hFFFF, (i == 0) ? 8'd255 : 8'd0);
    check("long_acc", acc24, 24'd16711425);
    check("long_ovf", ovf24, 1'b0);
    drain();
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prod_accumulator.md
PROD_ACCUMULATOR -- requirements
Module: prod_accumulator

Interface
REQ-001 SHALL provide parameter ACC_W, default 24: accumulator width in bits, minimum 17.
REQ-002 SHALL provide parameter CNT_W, default 8: width of the beat-count input.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1: a product beat is present on prod.
REQ-006 SHALL have port in_ready  output  1: the block accepts a beat this cycle.
REQ-007 SHALL have port prod  input  16: unsigned 8x8 approximate-multiplier product (prod8).
REQ-008 SHALL have port len  input  CNT_W: beats per accumulation, sampled only on the first beat.
REQ-009 SHALL have port out_valid  output  1: a result is held on acc_out.
REQ-010 SHALL have port out_ready  input  1: the downstream stage takes the result.
REQ-011 SHALL have port acc_out  output  ACC_W: the accumulated sum.
REQ-012 SHALL have port ovf  output  1: overflow occurred during this accumulation.

Function
REQ-013 SHALL implement states IDLE, ACC and DONE; a beat is accepted when in_valid and in_ready are both high.
REQ-014 IDLE and ACC SHALL drive in_ready=1 and out_valid=0; DONE SHALL drive in_ready=0 and out_valid=1.
REQ-015 IDLE accept SHALL load acc with zero-extended prod, clear ovf and load remaining with len-1; len=0 SHALL be treated as 1.
REQ-016 IDLE accept SHALL go to DONE when effective len is 1, otherwise to ACC.
REQ-017 ACC accept SHALL set acc to acc+prod and decrement remaining; it SHALL go to DONE when the beat accepted had remaining==1.
REQ-018 ACC without in_valid SHALL hold all state; bubbles SHALL be allowed between beats.
REQ-019 out_valid SHALL rise the cycle after the last beat is accepted (latency 1); acc_out and ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 DONE with out_ready=1 SHALL go to IDLE the next cycle; no new beat SHALL be accepted in that DONE cycle.
REQ-021 in_valid during DONE SHALL be ignored, with no state change.
REQ-022 acc_out SHALL show the live accumulator in all states; it is meaningful only when out_valid=1.

Reset
REQ-023 rst high SHALL immediately force IDLE, acc=0, remaining=0, ovf=0, out_valid=0 and in_ready=0 while asserted.
REQ-024 Reset mid-accumulation SHALL discard the partial sum; the first beat after release SHALL start a new accumulation.

Configuration
REQ-025 Macro PROD_ACC_SAT_EN SHALL select overflow behaviour.
REQ-026 With PROD_ACC_SAT_EN defined, an addition carrying out of ACC_W bits SHALL clamp acc to all-ones, set ovf, and hold all-ones for the rest of the accumulation.
REQ-027 Without PROD_ACC_SAT_EN, acc SHALL wrap modulo 2^ACC_W and ovf SHALL set sticky on any carry-out.

Verification
REQ-028 ACC_W=24, len=4, prods 10,20,30,40 back-to-back -> out_valid one cycle after the 4th beat, acc_out=100, ovf=0.
REQ-029 len=0, prod=0x1234 -> DONE after one beat, acc_out=0x001234.
REQ-030 ACC_W=17, len=3, prods 0xFFFF x3 -> without SAT_EN acc_out=65533 (0x0FFFD), ovf=1; with SAT_EN acc_out=0x1FFFF, ovf=1.
REQ-031 len=3 with in_valid gaps, then out_ready held low 5 cycles -> acc_out stable, in_ready=0, extra in_valid beats ignored; release -> IDLE next cycle.
REQ-032 rst pulsed after 2 of 4 beats -> outputs zero, IDLE; next len=1, prod=7 -> acc_out=7.
REQ-033 ACC_W=24, len=255, prods 0xFFFF every cycle -> acc_out=16711425, ovf=0.
